// File: rtl/rtp_audio_depack_pkg.sv
// rtl/rtp_audio_depack_pkg.sv - shared RTP constants, FSM encoding and counter helper
package rtp_audio_depack_pkg;

   localparam int          RTP_HDR_BYTES = 12;
   localparam logic [7:0]  RTP_V2_BYTE0  = 8'h80;
   localparam int          CNT_W         = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rtp_audio_depack_fifo.sv
// rtl/rtp_audio_depack_fifo.sv - single-clock sample FIFO with registered read data
module audio_sample_fifo #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [15:0]   push_data,
   input  logic          pop,
   output logic [15:0]   pop_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   logic [15:0]   mem [2**AW];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full    = level[AW];
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         pop_data <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) begin
            rd_ptr   <= rd_ptr + 1'b1;
            pop_data <= mem[rd_ptr];
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/rtp_audio_depack.sv
// rtl/rtp_audio_depack.sv - RTP/UDP receive parser feeding a prefilled PCM playback FIFO
module rtp_audio_depack
   import rtp_audio_depack_pkg::*;
#(
   parameter logic [31:0] SSRC         = 32'h12345678,
   parameter logic [6:0]  PAYLOAD_TYPE = 7'd0,
   parameter int          UDP_LENGTH   = 960,
   parameter int          FIFO_AW      = 10,
   parameter int          PREFILL      = 480
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               udp_rec_data_valid,
   input  logic [7:0]         udp_rec_rdata,
   input  logic [15:0]        udp_rec_data_length,
   input  logic               wav_rden,
   output logic [15:0]        wav_out_data,
   output logic               play_active,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [CNT_W-1:0]   pkt_good_cnt,
   output logic [CNT_W-1:0]   pkt_drop_cnt,
   output logic [CNT_W-1:0]   seq_lost_cnt,
   output logic [CNT_W-1:0]   underrun_cnt,
   output logic [CNT_W-1:0]   overflow_cnt
);

   state_t      state, state_next;
   logic [15:0] byte_cnt, len_q, seq_q, seq_exp, seq_gap;
   logic [16:0] lost_sum;
   logic        seq_armed;
   logic [7:0]  msb_q;
   logic        byte_ok, len_bad, hdr_pass, push_req, eop_good, eop_drop;
   logic        fifo_full, fifo_empty, pop, out_zero;
   logic [15:0] fifo_q;

   // Header byte check indexed by position; byte 0 is checked while still in IDLE.
   always_comb begin
      byte_ok = 1'b1;
      case (byte_cnt)
         16'd0:   byte_ok = (udp_rec_rdata == RTP_V2_BYTE0);
         16'd1:   byte_ok = (udp_rec_rdata[6:0] == PAYLOAD_TYPE);
         16'd8:   byte_ok = (udp_rec_rdata == SSRC[31:24]);
         16'd9:   byte_ok = (udp_rec_rdata == SSRC[23:16]);
         16'd10:  byte_ok = (udp_rec_rdata == SSRC[15:8]);
         16'd11:  byte_ok = (udp_rec_rdata == SSRC[7:0]);
         default: byte_ok = 1'b1;
      endcase
      len_bad = (udp_rec_data_length < 16'(RTP_HDR_BYTES + 2)) ||
                (udp_rec_data_length > 16'(UDP_LENGTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (udp_rec_data_valid)
                     state_next = (len_bad || !byte_ok) ? ST_DROP : ST_HDR;
         ST_HDR:  if (!udp_rec_data_valid)                        state_next = ST_IDLE;
                  else if (!byte_ok)                              state_next = ST_DROP;
                  else if (byte_cnt == 16'(RTP_HDR_BYTES - 1))    state_next = ST_PAYLOAD;
         default: if (!udp_rec_data_valid)                        state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      hdr_pass = (state == ST_HDR) && udp_rec_data_valid && byte_ok &&
                 (byte_cnt == 16'(RTP_HDR_BYTES - 1));
      push_req = (state == ST_PAYLOAD) && udp_rec_data_valid && byte_cnt[0];
      eop_good = (state == ST_PAYLOAD) && !udp_rec_data_valid && (byte_cnt == len_q);
      eop_drop = (state != ST_IDLE) && !udp_rec_data_valid && !eop_good;
   end

   assign seq_gap  = seq_q - seq_exp;
   assign lost_sum = {1'b0, seq_lost_cnt} + {1'b0, seq_gap};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt     <= '0;
         len_q        <= '0;
         seq_q        <= '0;
         seq_exp      <= '0;
         seq_armed    <= 1'b0;
         msb_q        <= '0;
         pkt_good_cnt <= '0;
         pkt_drop_cnt <= '0;
         seq_lost_cnt <= '0;
         overflow_cnt <= '0;
      end else begin
         byte_cnt <= udp_rec_data_valid ? byte_cnt + 1'b1 : '0;
         if (state == ST_IDLE && udp_rec_data_valid) len_q <= udp_rec_data_length;
         if (state == ST_HDR && udp_rec_data_valid && byte_cnt == 16'd2) seq_q[15:8] <= udp_rec_rdata;
         if (state == ST_HDR && udp_rec_data_valid && byte_cnt == 16'd3) seq_q[7:0]  <= udp_rec_rdata;
         if (state == ST_PAYLOAD && udp_rec_data_valid && !byte_cnt[0]) msb_q <= udp_rec_rdata;
         if (hdr_pass) begin
            if (seq_armed && seq_gap != 16'd0)
               seq_lost_cnt <= lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
            seq_exp   <= seq_q + 1'b1;
            seq_armed <= 1'b1;
         end
         if (eop_good) pkt_good_cnt <= sat_inc(pkt_good_cnt);
         if (eop_drop) pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
         if (push_req && fifo_full) overflow_cnt <= sat_inc(overflow_cnt);
      end
   end

   audio_sample_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_req),
      .push_data ({msb_q, udp_rec_rdata}),
      .pop       (pop),
      .pop_data  (fifo_q),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign pop = wav_rden && play_active && !fifo_empty;

   // out_zero masks the FIFO read register whenever a request could not pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         play_active  <= 1'b0;
         underrun_cnt <= '0;
         out_zero     <= 1'b1;
      end else begin
         if (wav_rden) out_zero <= !pop;
         if (wav_rden && play_active && fifo_empty) begin
            play_active  <= 1'b0;
            underrun_cnt <= sat_inc(underrun_cnt);
         end else if (!play_active && fifo_level >= (FIFO_AW+1)'(PREFILL)) begin
            play_active <= 1'b1;
         end
      end
   end

   assign wav_out_data = out_zero ? 16'h0000 : fifo_q;

endmodule

// File: tb/tb_rtp_audio_depack.sv
// tb/tb_rtp_audio_depack.sv - scoreboard bench for rtp_audio_depack
module tb_rtp_audio_depack;

   localparam logic [31:0] SSRC_OK = 32'h12345678;
   localparam int          MAXLEN  = 972;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  rdata = '0;
   logic [15:0] length = '0;
   logic        rden = 1'b0;
   logic [15:0] wav_out_data;
   logic        play_active;
   logic [10:0] fifo_level;
   logic [15:0] good_cnt, drop_cnt, lost_cnt, under_cnt, over_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] sb[$];
   int          m_level = 0, m_good = 0, m_drop = 0, m_lost = 0, m_under = 0, m_over = 0;
   bit          m_active = 0, m_armed = 0;
   logic [15:0] m_exp_seq = '0;

   always #5 clk = ~clk;

   rtp_audio_depack #(.UDP_LENGTH(MAXLEN)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .udp_rec_data_valid  (valid),
      .udp_rec_rdata       (rdata),
      .udp_rec_data_length (length),
      .wav_rden            (rden),
      .wav_out_data        (wav_out_data),
      .play_active         (play_active),
      .fifo_level          (fifo_level),
      .pkt_good_cnt        (good_cnt),
      .pkt_drop_cnt        (drop_cnt),
      .seq_lost_cnt        (lost_cnt),
      .underrun_cnt        (under_cnt),
      .overflow_cnt        (over_cnt)
   );

   function automatic logic [7:0] pkt_byte(input int i, input logic [15:0] seq,
                                           input logic [31:0] ssrc, input logic [6:0] pt,
                                           input logic [15:0] base);
      logic [31:0] t;
      logic [15:0] s;
      if (i == 0) return 8'h80;
      if (i == 1) return {1'b1, pt};
      if (i == 2) return seq[15:8];
      if (i == 3) return seq[7:0];
      if (i < 8)  return 8'(8'hA0 + i);
      if (i < 12) begin
         t = ssrc >> (8 * (11 - i));
         return t[7:0];
      end
      s = base + 16'((i - 12) / 2);
      return (i % 2 == 0) ? s[15:8] : s[7:0];
   endfunction

   function automatic void model_seq(input logic [15:0] seq);
      logic [15:0] gap;
      gap = seq - m_exp_seq;
      if (m_armed && gap != 0) m_lost = (m_lost + gap > 65535) ? 65535 : m_lost + gap;
      m_exp_seq = seq + 16'd1;
      m_armed = 1;
   endfunction

   task automatic send_pkt(input int len_field, input int nbytes, input logic [15:0] seq,
                           input logic [31:0] ssrc, input logic [6:0] pt,
                           input logic [15:0] base, input bit expect_push);
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         valid  = 1'b1;
         length = 16'(len_field);
         rdata  = pkt_byte(i, seq, ssrc, pt, base);
         if (expect_push && i >= 12 && (i % 2) == 1) begin
            if (m_level < 1024) begin
               sb.push_back(base + 16'((i - 12) / 2));
               m_level++;
            end else m_over++;
         end
      end
      @(negedge clk);
      valid = 1'b0;
      rdata = '0;
      repeat (3) @(negedge clk);
      if (m_level >= 480) m_active = 1;
   endtask

   task automatic do_read(input string name);
      logic [15:0] exp;
      @(negedge clk);
      rden = 1'b1;
      @(negedge clk);
      rden = 1'b0;
      if (m_active && sb.size() > 0) begin
         exp = sb.pop_front();
         m_level--;
      end else begin
         exp = 16'h0000;
         if (m_active) begin
            m_under++;
            m_active = 0;
         end
      end
      tests_run++;
      if (wav_out_data !== exp) begin
         tests_failed++;
         $display("FAIL %s: wav_out_data=%h expected %h", name, wav_out_data, exp);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({wav_out_data, play_active, fifo_level, good_cnt, drop_cnt, lost_cnt, under_cnt, over_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: out=%h act=%b lvl=%0d cnts=%0d/%0d/%0d/%0d/%0d expected all 0",
                  wav_out_data, play_active, fifo_level, good_cnt, drop_cnt, lost_cnt, under_cnt, over_cnt);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_packet;
      send_pkt(MAXLEN, MAXLEN, 16'd5, SSRC_OK, 7'd0, 16'h0100, 1);
      m_good++;
      model_seq(16'd5);
      tests_run++;
      if (fifo_level !== 11'(m_level)) begin
         tests_failed++; $display("FAIL good_level: %0d expected %0d", fifo_level, m_level);
      end
      tests_run++;
      if (good_cnt !== 16'(m_good)) begin
         tests_failed++; $display("FAIL good_cnt: %0d expected %0d", good_cnt, m_good);
      end
      tests_run++;
      if (play_active !== 1'b1) begin
         tests_failed++; $display("FAIL good_play_active: %b expected 1", play_active);
      end
      do_read("first_sample");
   endtask

   task automatic test_underrun;
      for (int k = 0; k < 480; k++) do_read("drain_sample");
      tests_run++;
      if (under_cnt !== 16'(m_under) || m_under != 1) begin
         tests_failed++; $display("FAIL underrun_cnt: %0d expected 1", under_cnt);
      end
      tests_run++;
      if (play_active !== 1'b0) begin
         tests_failed++; $display("FAIL underrun_play_active: %b expected 0", play_active);
      end
      do_read("read_after_underrun");
      tests_run++;
      if (under_cnt !== 16'd1 || fifo_level !== 11'd0) begin
         tests_failed++; $display("FAIL underrun_hold: under=%0d lvl=%0d expected 1/0", under_cnt, fifo_level);
      end
   endtask

   task automatic test_header_reject;
      send_pkt(MAXLEN, MAXLEN, 16'd6, 32'h12345679, 7'd0, 16'h0200, 0); m_drop++;
      tests_run++;
      if (drop_cnt !== 16'(m_drop) || fifo_level !== 11'(m_level)) begin
         tests_failed++; $display("FAIL bad_ssrc: drop=%0d lvl=%0d expected %0d/%0d", drop_cnt, fifo_level, m_drop, m_level);
      end
      send_pkt(13, 13, 16'd6, SSRC_OK, 7'd0, 16'h0200, 0); m_drop++;
      send_pkt(MAXLEN + 1, MAXLEN + 1, 16'd6, SSRC_OK, 7'd0, 16'h0200, 0); m_drop++;
      send_pkt(MAXLEN, 8, 16'd6, SSRC_OK, 7'd0, 16'h0200, 0); m_drop++;
      send_pkt(MAXLEN, MAXLEN, 16'd6, SSRC_OK, 7'd1, 16'h0200, 0); m_drop++;
      tests_run++;
      if (drop_cnt !== 16'(m_drop) || good_cnt !== 16'(m_good) || fifo_level !== 11'(m_level)) begin
         tests_failed++;
         $display("FAIL header_reject: drop=%0d good=%0d lvl=%0d expected %0d/%0d/%0d",
                  drop_cnt, good_cnt, fifo_level, m_drop, m_good, m_level);
      end
   endtask

   task automatic test_seq_gap;
      logic [15:0] seqs [3] = '{16'd8, 16'd9, 16'd3};
      for (int k = 0; k < 3; k++) begin
         send_pkt(16, 16, seqs[k], SSRC_OK, 7'd0, 16'h0300 + 16'(4 * k), 1);
         m_good++;
         model_seq(seqs[k]);
         tests_run++;
         if (lost_cnt !== 16'(m_lost)) begin
            tests_failed++; $display("FAIL seq_lost_%0d: %0d expected %0d", k, lost_cnt, m_lost);
         end
      end
      tests_run++;
      if (good_cnt !== 16'(m_good) || fifo_level !== 11'(m_level)) begin
         tests_failed++; $display("FAIL seq_pkts: good=%0d lvl=%0d expected %0d/%0d", good_cnt, fifo_level, m_good, m_level);
      end
      do_read("read_while_idle");
      tests_run++;
      if (fifo_level !== 11'(m_level)) begin
         tests_failed++; $display("FAIL idle_no_pop: lvl=%0d expected %0d", fifo_level, m_level);
      end
   endtask

   task automatic test_truncation;
      send_pkt(MAXLEN, 500, 16'd10, SSRC_OK, 7'd0, 16'h0400, 1);
      m_drop++;
      model_seq(16'd10);
      tests_run++;
      if (fifo_level !== 11'(m_level) || drop_cnt !== 16'(m_drop)) begin
         tests_failed++; $display("FAIL truncation: lvl=%0d drop=%0d expected %0d/%0d", fifo_level, drop_cnt, m_level, m_drop);
      end
   endtask

   task automatic test_reset_mid_packet;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         valid = 1'b1;
         length = 16'(MAXLEN);
         rdata = pkt_byte(i, 16'd20, SSRC_OK, 7'd0, 16'h0500);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({wav_out_data, play_active, fifo_level, good_cnt, drop_cnt, lost_cnt, under_cnt, over_cnt} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: out=%h lvl=%0d cnts=%0d/%0d/%0d/%0d/%0d expected all 0",
                  wav_out_data, fifo_level, good_cnt, drop_cnt, lost_cnt, under_cnt, over_cnt);
      end
      valid = 1'b0;
      rdata = '0;
      sb.delete();
      m_level = 0; m_good = 0; m_drop = 0; m_lost = 0; m_under = 0; m_over = 0;
      m_active = 0; m_armed = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overflow;
      for (int k = 0; k < 3; k++) begin
         send_pkt(MAXLEN, MAXLEN, 16'(100 + k), SSRC_OK, 7'd0, 16'h1000 * 16'(k + 1), 1);
         m_good++;
      end
      tests_run++;
      if (fifo_level !== 11'(m_level) || m_level != 1024) begin
         tests_failed++; $display("FAIL overflow_level: %0d expected 1024", fifo_level);
      end
      tests_run++;
      if (over_cnt !== 16'(m_over) || m_over != 416) begin
         tests_failed++; $display("FAIL overflow_cnt: %0d expected 416", over_cnt);
      end
      tests_run++;
      if (good_cnt !== 16'(m_good) || lost_cnt !== 16'd0 || play_active !== 1'b1) begin
         tests_failed++;
         $display("FAIL overflow_state: good=%0d lost=%0d act=%b expected %0d/0/1", good_cnt, lost_cnt, play_active, m_good);
      end
      for (int k = 0; k < 4; k++) do_read("post_overflow_sample");
   endtask

   initial begin
      test_reset();
      test_good_packet();
      test_underrun();
      test_header_reject();
      test_seq_gap();
      test_truncation();
      test_reset_mid_packet();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
